// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register-file geometry and the writeback source tag
// used by the writeback arbiter.
package riscv_pkg;

    localparam int REGISTER_INDEX_WIDTH = 5;
    localparam int REGISTER_COUNT       = 1 << REGISTER_INDEX_WIDTH;

    localparam logic [REGISTER_INDEX_WIDTH-1:0] X0 = '0;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/writeback_unit.sv
// Writeback stage: round-robin merge of ALU and load results into a single register-file
// write port, plus a busy-bit scoreboard with decode-stage forwarding and stall signals.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [REGISTER_INDEX_WIDTH-1:0] alu_rd,
    input  logic [XLEN-1:0]                 alu_data,

    input  logic                            mem_valid,
    output logic                            mem_ready,
    input  logic [REGISTER_INDEX_WIDTH-1:0] mem_rd,
    input  logic [XLEN-1:0]                 mem_data,

    output logic                            rd_wen,
    output logic [REGISTER_INDEX_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]                 rd_wdata,

    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [REGISTER_INDEX_WIDTH-1:0] issue_rd,

    input  logic [REGISTER_INDEX_WIDTH-1:0] rs1_addr,
    input  logic [REGISTER_INDEX_WIDTH-1:0] rs2_addr,

    output logic                            rs1_fwd,
    output logic [XLEN-1:0]                 rs1_fwd_data,
    output logic                            rs2_fwd,
    output logic [XLEN-1:0]                 rs2_fwd_data,

    output logic                            rs1_stall,
    output logic                            rs2_stall
);

    logic                            wb_valid_q, wb_valid_d;
    logic [REGISTER_INDEX_WIDTH-1:0] wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0]                 wb_data_q,  wb_data_d;
    logic [REGISTER_COUNT-1:0]       busy_q,     busy_d;
    wb_src_e                         last_grant_q, last_grant_d;

    logic grant_alu;
    logic grant_mem;
    logic issue_fire;

    // Arbitration; readies are forced low while reset is asserted.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                if (last_grant_q == WB_SRC_ALU) begin
                    grant_mem = 1'b1;
                end else begin
                    grant_alu = 1'b1;
                end
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    assign rd_wen   = wb_valid_q && (wb_rd_q != X0);
    assign rd_addr  = wb_rd_q;
    assign rd_wdata = wb_data_q;

    assign issue_ready = (issue_rd == X0) || !busy_q[issue_rd];
    assign issue_fire  = issue_valid && issue_ready;

    // The register file has no write-through, so the pending write is bypassed here.
    assign rs1_fwd      = rd_wen && (wb_rd_q == rs1_addr);
    assign rs2_fwd      = rd_wen && (wb_rd_q == rs2_addr);
    assign rs1_fwd_data = wb_data_q;
    assign rs2_fwd_data = wb_data_q;
    assign rs1_stall    = busy_q[rs1_addr] && !rs1_fwd;
    assign rs2_stall    = busy_q[rs2_addr] && !rs2_fwd;

    always_comb begin
        wb_valid_d   = grant_alu || grant_mem;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        last_grant_d = last_grant_q;
        if (grant_mem) begin
            wb_rd_d      = mem_rd;
            wb_data_d    = mem_data;
            last_grant_d = WB_SRC_MEM;
        end else if (grant_alu) begin
            wb_rd_d      = alu_rd;
            wb_data_d    = alu_data;
            last_grant_d = WB_SRC_ALU;
        end
    end

    // Retirement clears first so that a same-edge issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (rd_wen) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        if (issue_fire && (issue_rd != X0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[X0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            busy_q       <= '0;
            last_grant_q <= WB_SRC_ALU;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of arbitration and scoreboard.
module tb_writeback_unit;
    import riscv_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = REGISTER_INDEX_WIDTH;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 1'b0;
    logic [RW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            mem_valid = 1'b0;
    logic [RW-1:0]   mem_rd = '0;
    logic [XLEN-1:0] mem_data = '0;
    logic            issue_valid = 1'b0;
    logic [RW-1:0]   issue_rd = '0;
    logic [RW-1:0]   rs1_addr = '0;
    logic [RW-1:0]   rs2_addr = '0;

    logic            alu_ready, mem_ready, rd_wen, issue_ready;
    logic [RW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_wdata, rs1_fwd_data, rs2_fwd_data;
    logic            rs1_fwd, rs2_fwd, rs1_stall, rs2_stall;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: set of reserved registers, the one result awaiting its write,
    // and which channel won most recently.
    bit              m_busy [REGISTER_COUNT];
    bit              m_pend_valid = 1'b0;
    logic [RW-1:0]   m_pend_rd = '0;
    logic [XLEN-1:0] m_pend_data = '0;
    bit              m_last_mem = 1'b0;

    writeback_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_fwd(rs1_fwd), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data),
        .rs1_stall(rs1_stall), .rs2_stall(rs2_stall)
    );

    initial forever #5 clk = ~clk;

    function automatic bit exp_alu_grant();
        if (rst) return 1'b0;
        if (alu_valid && mem_valid) return m_last_mem;
        return alu_valid;
    endfunction

    function automatic bit exp_mem_grant();
        if (rst) return 1'b0;
        if (alu_valid && mem_valid) return !m_last_mem;
        return mem_valid;
    endfunction

    function automatic bit exp_wen();
        return m_pend_valid && (m_pend_rd != 0);
    endfunction

    function automatic bit exp_issue_ready();
        return (issue_rd == 0) || !m_busy[issue_rd];
    endfunction

    function automatic bit exp_fwd(input logic [RW-1:0] rs);
        return exp_wen() && (m_pend_rd == rs);
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update on every clock edge, or immediately on reset assertion.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_pend_valid = 1'b0;
            m_pend_rd    = '0;
            m_pend_data  = '0;
            m_last_mem   = 1'b0;
        end else begin
            bit ga, gm, wen, iss;
            logic [RW-1:0] retire_rd;
            ga        = exp_alu_grant();
            gm        = exp_mem_grant();
            wen       = exp_wen();
            iss       = issue_valid && exp_issue_ready();
            retire_rd = m_pend_rd;
            if (wen) m_busy[retire_rd] = 1'b0;
            if (iss && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (gm) begin
                m_pend_valid = 1'b1; m_pend_rd = mem_rd; m_pend_data = mem_data; m_last_mem = 1'b1;
            end else if (ga) begin
                m_pend_valid = 1'b1; m_pend_rd = alu_rd; m_pend_data = alu_data; m_last_mem = 1'b0;
            end else begin
                m_pend_valid = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        checkOutput("alu_ready", alu_ready, exp_alu_grant());
        checkOutput("mem_ready", mem_ready, exp_mem_grant());
        checkOutput("rd_wen", rd_wen, exp_wen());
        if (exp_wen()) begin
            checkOutput("rd_addr", rd_addr, m_pend_rd);
            checkOutput("rd_wdata", rd_wdata, m_pend_data);
        end
        checkOutput("issue_ready", issue_ready, exp_issue_ready());
        checkOutput("rs1_fwd", rs1_fwd, exp_fwd(rs1_addr));
        checkOutput("rs2_fwd", rs2_fwd, exp_fwd(rs2_addr));
        if (exp_fwd(rs1_addr)) checkOutput("rs1_fwd_data", rs1_fwd_data, m_pend_data);
        if (exp_fwd(rs2_addr)) checkOutput("rs2_fwd_data", rs2_fwd_data, m_pend_data);
        checkOutput("rs1_stall", rs1_stall, m_busy[rs1_addr] && !exp_fwd(rs1_addr));
        checkOutput("rs2_stall", rs2_stall, m_busy[rs2_addr] && !exp_fwd(rs2_addr));
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
        alu_data = '0; mem_data = '0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One cycle of random traffic; small register range forces hazards and collisions.
    task automatic applyStimulus();
        alu_valid   = ($urandom_range(0, 1) == 1);
        mem_valid   = ($urandom_range(0, 2) == 0);
        alu_rd      = RW'($urandom_range(0, 7));
        mem_rd      = RW'($urandom_range(0, 7));
        alu_data    = $urandom;
        mem_data    = $urandom;
        issue_valid = ($urandom_range(0, 1) == 1);
        issue_rd    = RW'($urandom_range(0, 7));
        rs1_addr    = RW'($urandom_range(0, 7));
        rs2_addr    = RW'($urandom_range(0, 7));
        if (rst) rst = 1'b0;
        else if ($urandom_range(0, 199) == 0) rst = 1'b1;
    endtask

    initial begin
        bit grant_mem_order [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int busy_seen;

        rst = 1'b1;
        tick();
        checkOutput("reset_alu_ready", alu_ready, 0);
        checkOutput("reset_mem_ready", mem_ready, 0);
        checkOutput("reset_rd_wen", rd_wen, 0);
        checkOutput("reset_issue_ready", issue_ready, 1);
        checkOutput("reset_rs1_stall", rs1_stall, 0);
        tick();
        rst = 1'b0;

        // Lone ALU result, one-cycle latency to the write port.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1234_5678;
        #1;
        checkOutput("alu_alone_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        #1;
        checkOutput("alu_alone_wen", rd_wen, 1);
        checkOutput("alu_alone_addr", rd_addr, 1);
        checkOutput("alu_alone_wdata", rd_wdata, 32'h1234_5678);
        checkOutput("model_pend_rd", m_pend_rd, 1);
        checkOutput("model_pend_data", m_pend_data, 32'h1234_5678);

        // Round-robin from reset: MEM, ALU, MEM, ALU.
        doReset();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'haaaa_0002;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hbbbb_0003;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("rr_mem_ready", mem_ready, grant_mem_order[i]);
            checkOutput("rr_alu_ready", alu_ready, !grant_mem_order[i]);
            tick();
        end
        clearInputs();

        // WAW issue stall on x5, then forward and release.
        doReset();
        issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
        #1;
        checkOutput("issue_first_ready", issue_ready, 1);
        checkOutput("rs1_stall_before_issue", rs1_stall, 0);
        tick();
        checkOutput("model_busy_x5", m_busy[5], 1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hdead_beef;
        #1;
        checkOutput("issue_waw_ready", issue_ready, 0);
        checkOutput("rs1_stall_busy", rs1_stall, 1);
        checkOutput("rs1_fwd_busy", rs1_fwd, 0);
        tick();
        alu_valid = 1'b0;
        #1;
        checkOutput("pending_wen", rd_wen, 1);
        checkOutput("rs1_fwd_pending", rs1_fwd, 1);
        checkOutput("rs1_fwd_data_pending", rs1_fwd_data, 32'hdead_beef);
        checkOutput("rs1_stall_pending", rs1_stall, 0);
        checkOutput("issue_ready_pending", issue_ready, 0);
        tick();
        checkOutput("issue_ready_retired", issue_ready, 1);
        clearInputs();

        // Load result to x0 is consumed without a write or scoreboard change.
        doReset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hffff_ffff;
        #1;
        checkOutput("x0_mem_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0; rs2_addr = 5'd7; rs1_addr = 5'd0;
        #1;
        checkOutput("x0_rd_wen", rd_wen, 0);
        checkOutput("x0_busy_x7_kept", rs2_stall, 1);
        checkOutput("x0_rs1_stall", rs1_stall, 0);
        checkOutput("x0_rs1_fwd", rs1_fwd, 0);
        tick();
        checkOutput("x0_rd_wen_later", rd_wen, 0);

        // Reset right after an accept loses the pending write.
        doReset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0055;
        tick();
        alu_valid = 1'b0;
        checkOutput("pre_reset_wen", rd_wen, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_wen", rd_wen, 0);
        busy_seen = 0;
        for (int r = 0; r < REGISTER_COUNT; r++) begin
            rs1_addr = RW'(r);
            #1;
            if (rs1_stall) busy_seen++;
        end
        checkOutput("mid_reset_busy_count", busy_seen, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("post_reset_no_write", rd_wen, 0);
            tick();
        end

        // Randomized traffic against the model.
        doReset();
        for (int c = 0; c < 2000; c++) begin
            applyStimulus();
            tick();
        end
        clearInputs();
        rst = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
